// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: register-file geometry,
// the load-result buffer entry and a one-hot helper for the busy scoreboard.
package writeback_arbiter_pkg;

  localparam int XLEN               = 32;
  localparam int REG_ADDR_W         = 5;
  localparam int REGS               = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [REGS-1:0] reg_onehot(input reg_addr_t r);
    logic [REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/load result inputs, issue/lookup ports and the register-file
// write port. The arbiter takes the slave side; the producer side is master.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN = writeback_arbiter_pkg::XLEN
);
  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  reg_addr_t       mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  reg_addr_t       issue_rd;
  reg_addr_t       rd_addrA;
  reg_addr_t       rd_addrB;
  logic            busyA;
  logic            busyB;
  reg_addr_t       wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            RegWrite;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, rd_addrA, rd_addrB,
    input  mem_ready, busyA, busyB, wr_addr, wr_data, RegWrite
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, rd_addrA, rd_addrB,
    output mem_ready, busyA, busyB, wr_addr, wr_data, RegWrite
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// In-order buffer for accepted load results. Push is ignored when full and pop
// when empty; the head is read straight from storage (no bypass of push data).
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by the ALU (priority) and a buffered
// load path, plus a busy scoreboard for registers with outstanding loads.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int XLEN       = writeback_arbiter_pkg::XLEN,
  parameter int REGS       = writeback_arbiter_pkg::REGS
) (
  input  logic               clk,
  input  logic               rst,
  writeback_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  wb_entry_t        mem_entry_s;
  wb_entry_t        head_s;
  logic             mem_ready_s;
  logic             push_s;
  logic             pop_s;

  logic             reg_write_q, reg_write_d;
  reg_addr_t        wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  logic [REGS-1:0]  busy_q, busy_d;
  logic [REGS-1:0]  set_mask_s;
  logic [REGS-1:0]  clr_mask_s;

  // Ready depends on current occupancy only; a same-cycle pop gives no credit.
  assign mem_ready_s = (fifo_count_s < CNT_W'(FIFO_DEPTH));
  assign push_s      = bus.mem_valid && mem_ready_s && !fifo_full_s;
  assign mem_entry_s = {bus.mem_rd, bus.mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (mem_entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  always_comb begin
    pop_s       = 1'b0;
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    clr_mask_s  = '0;
    if (bus.alu_valid) begin
      reg_write_d = (bus.alu_rd != 5'd0);
      wr_addr_d   = bus.alu_rd;
      wr_data_d   = bus.alu_data;
    end else if (!fifo_empty_s) begin
      pop_s       = 1'b1;
      reg_write_d = (head_s.rd != 5'd0);
      wr_addr_d   = head_s.rd;
      wr_data_d   = head_s.data;
      clr_mask_s  = reg_onehot(head_s.rd);
    end else begin
      reg_write_d = 1'b0;
    end
    // A new issue to the register being retired this cycle keeps it busy.
    set_mask_s = (bus.issue_valid && (bus.issue_rd != 5'd0)) ? reg_onehot(bus.issue_rd) : '0;
    busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    busy_d[0]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= {XLEN{1'b0}};
      busy_q      <= {REGS{1'b0}};
    end else begin
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_ready = mem_ready_s;
  assign bus.RegWrite  = reg_write_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busyA     = busy_q[bus.rd_addrA];
  assign bus.busyB     = busy_q[bus.rd_addrB];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the write port and scoreboard.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if bus ();

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ent_t        m_q[$];
  bit          m_busy [32];
  bit          m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = 5'd0;
    bus.mem_data    = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
  endtask

  // Model: ALU has priority, otherwise retire the oldest buffered load; loads
  // are accepted only while fewer than DEPTH are outstanding.
  task automatic tick();
    bit   ready;
    ent_t e;
    ready = (m_q.size() < DEPTH);
    if (rst) begin
      m_q.delete();
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      if (bus.alu_valid) begin
        m_we = (bus.alu_rd != 5'd0); m_addr = bus.alu_rd; m_data = bus.alu_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we = (e.rd != 5'd0); m_addr = e.rd; m_data = e.data;
        m_busy[e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
      if (bus.mem_valid && ready) m_q.push_back('{bus.mem_rd, bus.mem_data});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [40:0] obs_vec();
    return {bus.mem_ready, bus.busyA, bus.busyB, bus.RegWrite, bus.wr_addr, bus.wr_data};
  endfunction

  function automatic logic [40:0] exp_vec();
    return {(m_q.size() < DEPTH), m_busy[bus.rd_addrA], m_busy[bus.rd_addrB], m_we, m_addr, m_data};
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.rd_addrA = 5'd1; bus.rd_addrB = 5'd31;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
    end
  endtask

  task automatic test_alu_write();
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.RegWrite, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL alu_write: got %h expected %h", {bus.RegWrite, bus.wr_addr, bus.wr_data}, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.RegWrite, bus.wr_addr, bus.wr_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL alu_idle_hold: got %h expected %h", {bus.RegWrite, bus.wr_addr, bus.wr_data}, {1'b0, 5'd5, 32'hDEADBEEF});
    end
  endtask

  task automatic test_mem_busy();
    idle_inputs();
    bus.rd_addrA = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    idle_inputs();
    for (int i = 1; i <= 2; i++) begin
      #1;
      n_checks++;
      if (bus.busyA !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_after_issue: cycle %0d got %b expected 1", i, bus.busyA);
      end
      tick();
    end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h11;
    #1;
    n_checks++;
    if ({bus.busyA, bus.mem_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL push_cycle: got %b expected 11", {bus.busyA, bus.mem_ready});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.busyA, bus.RegWrite} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_bypass: got %b expected 10", {bus.busyA, bus.RegWrite});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.busyA, bus.RegWrite, bus.wr_addr, bus.wr_data} !== {1'b0, 1'b1, 5'd7, 32'h11}) begin
      n_fail++;
      $display("FAIL load_write: got %h expected %h", {bus.busyA, bus.RegWrite, bus.wr_addr, bus.wr_data}, {1'b0, 1'b1, 5'd7, 32'h11});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.busyA, bus.RegWrite} !== 2'b00) begin
      n_fail++;
      $display("FAIL after_load: got %b expected 00", {bus.busyA, bus.RegWrite});
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] got[$];
    bit          acc;
    idle_inputs();
    bus.rd_addrA = 5'd0; bus.rd_addrB = 5'd0;
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = $urandom;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + i); bus.mem_data = 32'hA0 + 32'(i);
      #1;
      n_checks++;
      if (bus.mem_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL bp_ready: push %0d got %b expected %b", i, bus.mem_ready, (i < 4));
      end
      tick();
    end
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k > 0 && bus.RegWrite === 1'b1) got.push_back({bus.wr_addr, bus.wr_data});
      acc = bus.mem_valid && bus.mem_ready;
      tick();
      if (acc) bus.mem_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL bp_write_count: got %0d expected 5", got.size());
    end
    for (int j = 0; j < 5 && j < got.size(); j++) begin
      n_checks++;
      if (got[j] !== {5'(10 + j), 32'hA0 + 32'(j)}) begin
        n_fail++;
        $display("FAIL bp_order: write %0d got %h expected %h", j, got[j], {5'(10 + j), 32'hA0 + 32'(j)});
      end
    end
  endtask

  task automatic test_rd_zero();
    idle_inputs();
    bus.rd_addrA = 5'd0; bus.rd_addrB = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = $urandom;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = $urandom;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.RegWrite, bus.busyA, bus.mem_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL rd_zero: cycle %0d got %b expected 001", i, {bus.RegWrite, bus.busyA, bus.mem_ready});
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rd_zero_model: got %h expected %h", obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_set_wins();
    idle_inputs();
    bus.rd_addrA = 5'd9;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle_inputs();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
    tick();
    idle_inputs();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.busyA, bus.RegWrite, bus.wr_addr} !== {1'b1, 1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL set_wins: got %h expected %h", {bus.busyA, bus.RegWrite, bus.wr_addr}, {1'b1, 1'b1, 5'd9});
    end
    tick();
    #1;
    n_checks++;
    if (bus.busyA !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_hold: got %b expected 1", bus.busyA);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.rd_addrA = 5'd3; bus.rd_addrB = 5'd4;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick();
    bus.issue_rd = 5'd4;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = $urandom;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(20 + i); bus.mem_data = $urandom;
      tick();
    end
    #1;
    n_checks++;
    if ({bus.busyA, bus.busyB} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got %b expected 11", {bus.busyA, bus.busyB});
    end
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    bus.rd_addrB = 5'd5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.rd_addrB = 5'd4;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ({bus.mem_ready, bus.busyA, bus.busyB, bus.RegWrite} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_mid: cycle %0d got %b expected 1000", i, {bus.mem_ready, bus.busyA, bus.busyB, bus.RegWrite});
      end
      if (i == 0) bus.rd_addrB = 5'd5;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.alu_valid   = ($urandom_range(0, 2) == 0);
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.mem_valid   = ($urandom_range(0, 1) == 1);
      bus.mem_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.mem_data    = $urandom;
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.rd_addrA    = 5'($urandom_range(0, 31));
      bus.rd_addrB    = 5'($urandom_range(0, 31));
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.rd_addrA = 5'd0;
    bus.rd_addrB = 5'd0;
    test_reset();
    test_alu_write();
    test_mem_busy();
    test_backpressure();
    test_rd_zero();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, depth of load-result buffer (power of two, >=2).
REQ-002 SHALL have parameters XLEN, default 32, data width; REGS, default 32, register count (5-bit address).
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  single-cycle result present; always accepted, no ready.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 mem_valid  input  1  load/long-latency result offered.
REQ-009 mem_ready  output  1  buffer can accept mem result this cycle.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load result.
REQ-012 issue_valid  input  1  long-latency op issued this cycle.
REQ-013 issue_rd  input  5  destination of issued long-latency op.
REQ-014 rd_addrA, rd_addrB  input  5 each  source registers to check.
REQ-015 busyA, busyB  output  1 each  source has a pending long-latency write.
REQ-016 wr_addr  output  5  register-file write address.
REQ-017 wr_data  output  32  register-file write data.
REQ-018 RegWrite  output  1  register-file write enable.

Function
REQ-019 mem handshake: transfer when mem_valid && mem_ready; mem_ready = (count < FIFO_DEPTH), from current count only, no same-cycle pop credit.
REQ-020 Accepted mem results SHALL enter a FIFO in order; no bypass, so an accepted mem result reaches the write port no earlier than 2 cycles after acceptance.
REQ-021 Port arbitration per cycle: alu_valid wins; else if FIFO non-empty, pop head; else idle.
REQ-022 FIFO head SHALL be held unchanged while alu_valid is high (no loss, no reorder).
REQ-023 Write port outputs SHALL be registered: selected source appears on wr_addr/wr_data/RegWrite the cycle after selection.
REQ-024 Selected destination 0: RegWrite SHALL stay 0; entry still consumed (ALU) or popped (FIFO).
REQ-025 Idle cycle: RegWrite = 0; wr_addr/wr_data hold previous values.
REQ-026 Scoreboard: one busy bit per register; issue_valid with issue_rd != 0 sets bit issue_rd next cycle.
REQ-027 FIFO pop of entry with rd = r SHALL clear bit r next cycle.
REQ-028 Same-cycle set and clear of same register: set wins.
REQ-029 Bit 0 SHALL be constant 0; issue to x0 ignored.
REQ-030 busyA = bit[rd_addrA], busyB = bit[rd_addrB], combinational from scoreboard state.
REQ-031 Simultaneous push and pop with FIFO non-empty and not full: both occur, count unchanged.
REQ-032 Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH, never overflows or underflows.

Reset
REQ-033 While rst high at posedge: FIFO count, read/write pointers 0; all scoreboard bits 0; RegWrite 0; wr_addr 0; wr_data 0; mem_ready 1 the cycle after.
REQ-034 Reset mid-operation SHALL discard all buffered mem results and pending busy bits; same-cycle inputs ignored.
REQ-035 FIFO storage array need not be reset.

Structure
REQ-036 Shared package SHALL hold XLEN, REG_ADDR_W (5), REGS, default FIFO_DEPTH, and a wb_entry type {rd[4:0], data[31:0]}.
REQ-037 FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty/count, synchronous reset); arbitration, scoreboard and output registers in writeback_arbiter.

Verification
REQ-038 Reset, alu_valid=1 rd=5 data=0xDEADBEEF one cycle -> next cycle RegWrite=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle RegWrite=0.
REQ-039 issue rd=7; 3 cycles later mem push rd=7 data=0x11 with alu idle -> busyA(rd_addrA=7)=1 until write cycle; RegWrite rd=7 data=0x11 2 cycles after push; busyA=0 after.
REQ-040 5 consecutive mem pushes with alu_valid held 1 -> 4 accepted, mem_ready=0 on 5th; after alu drops, 4 writes in push order, then 5th accepted.
REQ-041 alu and mem both rd=0 -> entries consumed, RegWrite never 1, scoreboard bit 0 stays 0.
REQ-042 issue rd=9 in same cycle as pop of rd=9 -> busy bit 9 remains 1.
REQ-043 rst asserted with 3 FIFO entries and 2 busy bits -> next cycle count=0, all busy 0, RegWrite=0, no buffered writes emerge.
